// File: rtl/btn_debounce.sv
// Push-button conditioner: per-channel two-flop synchroniser, stability counter,
// debounced level and registered one-cycle press/release strobes.
module btn_debounce #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic             CLK100MHZ,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    ACCEPT
  } phase_t;

  // The edge where s2 first differs counts as 0, so the level moves on edge
  // E+2+DEBOUNCE_CYCLES; the counter therefore reaches DEBOUNCE_CYCLES itself.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES);

  logic [N_BTN-1:0] s1;
  logic [N_BTN-1:0] s2;

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             level_q;
    logic             press_q;
    logic             release_q;
    logic             level_nxt;
    logic             press_nxt;
    logic             release_nxt;
    phase_t           phase;

    always_comb begin
      phase       = IDLE;
      cnt_nxt     = '0;
      level_nxt   = level_q;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      if (s2[g] != level_q) begin
        phase = (cnt == CNT_LAST) ? ACCEPT : COUNT;
      end
      case (phase)
        COUNT: begin
          cnt_nxt = cnt + CNT_W'(1);
        end
        ACCEPT: begin
          level_nxt   = s2[g];
          press_nxt   = s2[g];
          release_nxt = ~s2[g];
        end
        default: begin
          cnt_nxt = '0;
        end
      endcase
    end

    always_ff @(posedge CLK100MHZ) begin
      if (reset) begin
        cnt       <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        cnt       <= cnt_nxt;
        level_q   <= level_nxt;
        press_q   <= press_nxt;
        release_q <= release_nxt;
      end
    end

    assign btn_level[g]   = level_q;
    assign btn_press[g]   = press_q;
    assign btn_release[g] = release_q;
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce with a short debounce window.
module tb_btn_debounce;

  localparam int N_BTN = 5;
  localparam int DC    = 8;
  localparam int CW    = 4;
  localparam int LAT   = DC + 2;

  typedef struct {
    int unsigned      cyc;
    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] rel;
    logic [N_BTN-1:0] level;
  } ev_t;

  logic             CLK100MHZ = 1'b0;
  logic             reset     = 1'b1;
  logic [N_BTN-1:0] btn_in    = '0;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;

  int unsigned      cyc      = 0;
  int unsigned      n_tests  = 0;
  int unsigned      n_fail   = 0;
  logic [N_BTN-1:0] exp_level = '0;
  ev_t              sb[$];

  btn_debounce #(
    .N_BTN(N_BTN),
    .DEBOUNCE_CYCLES(DC),
    .CNT_W(CW)
  ) dut (
    .CLK100MHZ(CLK100MHZ),
    .reset(reset),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;
  always @(posedge CLK100MHZ) cyc <= cyc + 1;

  task automatic step();
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK100MHZ);
      n_tests++;
      if ({btn_level, btn_press, btn_release} !== '0) begin
        n_fail++;
        $display("FAIL reset_state: level=%b press=%b rel=%b, required all 0", btn_level, btn_press, btn_release);
      end
    end
    step();
    reset = 1'b0;
  endtask

  task automatic test_clean_press();
    step();
    btn_in[0] = 1'b1;
    sb.push_back('{cyc + 1 + LAT, 5'b00001, 5'b00000, 5'b00001});
    for (int i = 0; i < 22; i++) begin
      @(negedge CLK100MHZ);
      n_tests++;
      if (sb.size() != 0 && cyc == sb[0].cyc) begin
        if (btn_press !== sb[0].press || btn_release !== sb[0].rel || btn_level !== sb[0].level) begin
          n_fail++;
          $display("FAIL clean_press_event: press=%b rel=%b level=%b, required press=%b rel=%b level=%b",
                   btn_press, btn_release, btn_level, sb[0].press, sb[0].rel, sb[0].level);
        end
        exp_level = sb[0].level;
        void'(sb.pop_front());
      end else if (btn_press !== '0 || btn_release !== '0 || btn_level !== exp_level) begin
        n_fail++;
        $display("FAIL clean_press_idle: cyc=%0d press=%b rel=%b level=%b, required press=0 rel=0 level=%b",
                 cyc, btn_press, btn_release, btn_level, exp_level);
      end
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL clean_press_timeout: %0d events pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_glitch();
    step();
    btn_in[2] = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge CLK100MHZ);
      n_tests++;
      if (btn_press !== '0 || btn_release !== '0 || btn_level !== exp_level) begin
        n_fail++;
        $display("FAIL glitch: cyc=%0d press=%b rel=%b level=%b, required press=0 rel=0 level=%b",
                 cyc, btn_press, btn_release, btn_level, exp_level);
      end
      if (i == 5) btn_in[2] = 1'b0;
    end
  endtask

  task automatic test_bounce();
    int unsigned t_last;
    step();
    t_last = 0;
    for (int i = 0; i < 5; i++) begin
      btn_in[3] = (i % 2 == 0);
      t_last = cyc;
      if (i < 4) begin
        repeat (2) @(posedge CLK100MHZ);
        step();
      end
    end
    sb.push_back('{t_last + 1 + LAT, 5'b01000, 5'b00000, 5'b01001});
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK100MHZ);
      n_tests++;
      if (sb.size() != 0 && cyc == sb[0].cyc) begin
        if (btn_press !== sb[0].press || btn_release !== sb[0].rel || btn_level !== sb[0].level) begin
          n_fail++;
          $display("FAIL bounce_event: press=%b rel=%b level=%b, required press=%b rel=%b level=%b",
                   btn_press, btn_release, btn_level, sb[0].press, sb[0].rel, sb[0].level);
        end
        exp_level = sb[0].level;
        void'(sb.pop_front());
      end else if (btn_press !== '0 || btn_release !== '0 || btn_level !== exp_level) begin
        n_fail++;
        $display("FAIL bounce_idle: cyc=%0d press=%b rel=%b level=%b, required press=0 rel=0 level=%b",
                 cyc, btn_press, btn_release, btn_level, exp_level);
      end
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL bounce_timeout: %0d events pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  // Releases channels 0 and 3 together, then presses 1,2,4 together, then releases those.
  task automatic test_back_to_back();
    logic [N_BTN-1:0] pat[3];
    logic [N_BTN-1:0] prev;
    pat[0] = 5'b00000;
    pat[1] = 5'b10110;
    pat[2] = 5'b00000;
    for (int p = 0; p < 3; p++) begin
      step();
      prev   = btn_in;
      btn_in = pat[p];
      sb.push_back('{cyc + 1 + LAT, pat[p] & ~prev, prev & ~pat[p], pat[p]});
      for (int i = 0; i < 16; i++) begin
        @(negedge CLK100MHZ);
        n_tests++;
        if (sb.size() != 0 && cyc == sb[0].cyc) begin
          if (btn_press !== sb[0].press || btn_release !== sb[0].rel || btn_level !== sb[0].level) begin
            n_fail++;
            $display("FAIL back_to_back_event%0d: press=%b rel=%b level=%b, required press=%b rel=%b level=%b",
                     p, btn_press, btn_release, btn_level, sb[0].press, sb[0].rel, sb[0].level);
          end
          exp_level = sb[0].level;
          void'(sb.pop_front());
        end else if (btn_press !== '0 || btn_release !== '0 || btn_level !== exp_level) begin
          n_fail++;
          $display("FAIL back_to_back_idle%0d: cyc=%0d press=%b rel=%b level=%b, required press=0 rel=0 level=%b",
                   p, cyc, btn_press, btn_release, btn_level, exp_level);
        end
      end
      if (sb.size() != 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL back_to_back_timeout%0d: %0d events pending, required 0", p, sb.size());
        sb.delete();
      end
    end
  endtask

  task automatic test_reset_mid();
    int unsigned k;
    step();
    btn_in[1] = 1'b1;
    k = cyc;
    // count would reach 5 at edge k+7; reset is sampled at k+8, released for k+9
    sb.push_back('{k + 9 + LAT, 5'b00010, 5'b00000, 5'b00010});
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK100MHZ);
      n_tests++;
      if (sb.size() != 0 && cyc == sb[0].cyc) begin
        if (btn_press !== sb[0].press || btn_release !== sb[0].rel || btn_level !== sb[0].level) begin
          n_fail++;
          $display("FAIL reset_mid_event: press=%b rel=%b level=%b, required press=%b rel=%b level=%b",
                   btn_press, btn_release, btn_level, sb[0].press, sb[0].rel, sb[0].level);
        end
        exp_level = sb[0].level;
        void'(sb.pop_front());
      end else if (btn_press !== '0 || btn_release !== '0 || btn_level !== exp_level) begin
        n_fail++;
        $display("FAIL reset_mid_idle: cyc=%0d press=%b rel=%b level=%b, required press=0 rel=0 level=%b",
                 cyc, btn_press, btn_release, btn_level, exp_level);
      end
      if (cyc == k + 7) reset = 1'b1;
      if (cyc == k + 8) reset = 1'b0;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL reset_mid_timeout: %0d events pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_bounce();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
